route_dispatch: RTL and testbench

//  Downstream of the router's shared flit FIFO; drives the five output transceivers (N,S,E,W,L).

---
 rtl/route_dispatch_pkg.sv | 22 ++
 rtl/route_dispatch_demux.sv | 25 ++
 rtl/route_dispatch.sv | 99 +++++++++
 tb/tb_route_dispatch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/route_dispatch_pkg.sv
// Shared widths, lane encoding and flit types for the router output dispatch stage.
package route_dispatch_pkg;

  localparam int SIZE      = 8;
  localparam int BITS_DIR  = 3;
  localparam int NUM_LANES = 5;

  typedef logic [SIZE-1:0]     flit_t;
  typedef logic [BITS_DIR-1:0] dir_t;

  localparam dir_t DIR_NORTH = 3'd0;
  localparam dir_t DIR_SOUTH = 3'd1;
  localparam dir_t DIR_EAST  = 3'd2;
  localparam dir_t DIR_WEST  = 3'd3;
  localparam dir_t DIR_LOCAL = 3'd4;
  localparam dir_t DIR_COUNT = 3'd5;

  function automatic logic dir_valid(input dir_t d);
    return d < DIR_COUNT;
  endfunction

endpackage

// File: rtl/route_dispatch_demux.sv
// Combinational lane fan-out: steers one request and one flit onto the selected lane.
// Zero latency; out-of-range selects leave every lane idle.
module route_dispatch_demux
  import route_dispatch_pkg::*;
(
  input  logic                      req,
  input  logic                      dat_en,
  input  dir_t                      sel,
  input  flit_t                     flit,
  output logic [NUM_LANES-1:0]      lane_req,
  output logic [NUM_LANES*SIZE-1:0] lane_dat
);

  always_comb begin
    lane_req = '0;
    lane_dat = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (sel == dir_t'(k)) begin
        lane_req[k]              = req;
        lane_dat[k*SIZE +: SIZE] = dat_en ? flit : '0;
      end
    end
  end

endmodule

// File: rtl/route_dispatch.sv
// Pops one flit, looks up its output lane, then runs a 4-phase req/ack on that lane only.
// One flit in flight, 4+TABLE_LAT cycles minimum per flit; stalls in SEND/RELEASE until the lane acks.
module route_dispatch
  import route_dispatch_pkg::*;
#(
  parameter int TABLE_LAT = 1  // legal 0..3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fifo_empty,
  input  logic [SIZE-1:0]           fifo_data_out,
  output logic                      fifo_read,
  output logic [SIZE-1:0]           table_addr,
  input  logic [BITS_DIR-1:0]       table_data,
  output logic [NUM_LANES-1:0]      fifo_pop_req,
  input  logic [NUM_LANES-1:0]      fifo_pop_ack,
  output logic [NUM_LANES*SIZE-1:0] fifo_pop_data,
  output logic                      busy,
  output logic [15:0]               drop_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOOKUP  = 2'd1;
  localparam logic [1:0] ST_SEND    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;
  localparam logic [1:0] LAT        = 2'(TABLE_LAT);

  logic [1:0]                state, state_nxt, wait_cnt;
  flit_t                     flit_r;
  dir_t                      sel_r, sel_nxt;
  logic                      lookup_done, route_ok, ack_sel, req_nxt, dat_en_nxt;
  logic [NUM_LANES-1:0]      lane_req;
  logic [NUM_LANES*SIZE-1:0] lane_dat;

  assign lookup_done = (state == ST_LOOKUP) && (wait_cnt == LAT);
  assign route_ok    = dir_valid(table_data);
  assign ack_sel     = fifo_pop_ack[sel_r];
  assign sel_nxt     = (state == ST_LOOKUP) ? table_data : sel_r;
  assign table_addr  = flit_r;
  assign busy        = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    req_nxt    = 1'b0;
    dat_en_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (lookup_done) state_nxt = route_ok ? ST_SEND : ST_IDLE;
        req_nxt    = lookup_done && route_ok;
        dat_en_nxt = lookup_done && route_ok;
      end
      ST_SEND: begin
        if (ack_sel) state_nxt = ST_RELEASE;
        req_nxt    = !ack_sel;
        dat_en_nxt = 1'b1;
      end
      default: begin
        // Bundled data stays on the lane until the receiver drops ack.
        if (!ack_sel) state_nxt = ST_IDLE;
        dat_en_nxt = ack_sel;
      end
    endcase
  end

  route_dispatch_demux u_demux (
    .req      (req_nxt),
    .dat_en   (dat_en_nxt),
    .sel      (sel_nxt),
    .flit     (flit_r),
    .lane_req (lane_req),
    .lane_dat (lane_dat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      flit_r        <= '0;
      sel_r         <= '0;
      fifo_read     <= 1'b0;
      fifo_pop_req  <= '0;
      fifo_pop_data <= '0;
      drop_count    <= '0;
    end else begin
      state         <= state_nxt;
      fifo_read     <= (state == ST_IDLE) && !fifo_empty;
      fifo_pop_req  <= lane_req;
      fifo_pop_data <= lane_dat;
      if (state == ST_IDLE && !fifo_empty) flit_r <= fifo_data_out;
      wait_cnt <= (state == ST_LOOKUP && !lookup_done) ? wait_cnt + 2'd1 : 2'd0;
      if (lookup_done) sel_r <= table_data;
      if (lookup_done && !route_ok && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_route_dispatch.sv
// Scoreboard bench for route_dispatch: FIFO, routing-table and per-lane transceiver models.
module tb_route_dispatch;
  import route_dispatch_pkg::*;

  localparam int LAT = 3;

  typedef struct packed {
    dir_t  port;
    flit_t flit;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      fifo_empty = 1'b1;
  logic [SIZE-1:0]           fifo_data_out = '0;
  logic                      fifo_read;
  logic [SIZE-1:0]           table_addr;
  logic [BITS_DIR-1:0]       table_data = '0;
  logic [NUM_LANES-1:0]      fifo_pop_req;
  logic [NUM_LANES-1:0]      fifo_pop_ack = '0;
  logic [NUM_LANES*SIZE-1:0] fifo_pop_data;
  logic                      busy;
  logic [15:0]               drop_count;

  route_dispatch #(.TABLE_LAT(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_read     (fifo_read),
    .table_addr    (table_addr),
    .table_data    (table_data),
    .fifo_pop_req  (fifo_pop_req),
    .fifo_pop_ack  (fifo_pop_ack),
    .fifo_pop_data (fifo_pop_data),
    .busy          (busy),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  flit_t fifo_q[$];
  dir_t tbl [256];
  dir_t pipe [4];
  int   exp_drops = 0;
  int   n_reads = 0;
  int   ack_dly = 1;
  int   ack_cnt [NUM_LANES];
  logic [NUM_LANES-1:0] spur = '0;
  logic [NUM_LANES-1:0] ack_m = '0;
  logic [NUM_LANES-1:0] req_prev = '0;
  logic [NUM_LANES-1:0] rise;
  logic mon_on = 1'b0;
  logic mon_acked = 1'b0;
  logic rd_prev = 1'b0;
  int   mon_lane = 0;
  flit_t mon_flit = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_LANES*SIZE-1:0] lane_bus(input int lane, input flit_t f);
    logic [NUM_LANES*SIZE-1:0] b;
    b = '0;
    b[lane*SIZE +: SIZE] = f;
    return b;
  endfunction

  function automatic int lane_of(input logic [NUM_LANES-1:0] v);
    for (int k = 0; k < NUM_LANES; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic push(input flit_t f);
    fifo_q.push_back(f);
    if (tbl[f] < DIR_COUNT) exp_q.push_back('{port: tbl[f], flit: f});
    else exp_drops++;
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 400 && quiet < 3; i++) begin
      @(posedge clk); #2;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy && !mon_on) quiet++;
      else quiet = 0;
    end
    check("drain_busy", busy, 0);
    check("drain_pending", exp_q.size(), 0);
    check("drain_fifo", fifo_q.size(), 0);
  endtask

  // Models sample DUT outputs first, then update their own outputs, all on the falling edge.
  initial begin
    for (int k = 0; k < NUM_LANES; k++) ack_cnt[k] = 0;
    for (int k = 0; k < 4; k++) pipe[k] = '0;
    forever begin
      @(negedge clk);
      if (fifo_read) begin
        check("rd_single", rd_prev, 0);
        check("rd_idle", mon_on, 0);
        check("rd_nonempty", fifo_q.size() != 0, 1);
        if (fifo_q.size() != 0) fifo_q.delete(0);
        n_reads++;
      end
      rd_prev = fifo_read;
      if (!reset) begin
        ack_m = '0;
        for (int k = 0; k < NUM_LANES; k++) ack_cnt[k] = 0;
        req_prev = '0;
        mon_on = 1'b0;
      end else begin
        if (mon_on) begin
          if (fifo_pop_ack[mon_lane]) check("req_release", fifo_pop_req[mon_lane], 0);
          else if (!mon_acked) check("req_hold", fifo_pop_req[mon_lane], 1);
          if (mon_acked && !fifo_pop_ack[mon_lane]) begin
            check("data_clear", fifo_pop_data, 0);
            check("idle_after", busy, 0);
            mon_on = 1'b0;
          end else begin
            check("data_hold", fifo_pop_data, lane_bus(mon_lane, mon_flit));
          end
          mon_acked = mon_acked | fifo_pop_ack[mon_lane];
        end
        rise = fifo_pop_req & ~req_prev;
        if (rise != '0) begin
          check("req_onehot", $countones(fifo_pop_req), 1);
          if (exp_q.size() == 0) begin
            check("req_unexpected", rise, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("req_lane", lane_of(rise), e.port);
            check("req_data", fifo_pop_data, lane_bus(int'(e.port), e.flit));
            mon_on = 1'b1;
            mon_acked = 1'b0;
            mon_lane = int'(e.port);
            mon_flit = e.flit;
          end
        end
        req_prev = fifo_pop_req;
        for (int k = 0; k < NUM_LANES; k++) begin
          if (fifo_pop_req[k] && !ack_m[k]) begin
            if (ack_cnt[k] >= ack_dly) ack_m[k] = 1'b1;
            else ack_cnt[k]++;
          end else if (!fifo_pop_req[k] && ack_m[k]) begin
            ack_m[k] = 1'b0;
            ack_cnt[k] = 0;
          end
        end
      end
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = tbl[table_addr];
      table_data = pipe[LAT];
      fifo_pop_ack = ack_m | spur;
      fifo_empty = (fifo_q.size() == 0);
      fifo_data_out = fifo_empty ? '0 : fifo_q[0];
    end
  end

  initial begin
    int r0;
    for (int i = 0; i < 256; i++) tbl[i] = dir_t'(i % 5);
    tbl[8'h11] = 3'd6;
    tbl[8'h4C] = DIR_LOCAL;
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset held with a flit waiting: nothing may move.
    ack_dly = 2;
    push(8'h2A);
    repeat (4) @(posedge clk);
    #2;
    check("rst_req", fifo_pop_req, 0);
    check("rst_data", fifo_pop_data, 0);
    check("rst_read", fifo_read, 0);
    check("rst_addr", table_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_drops", drop_count, 0);
    check("rst_no_pop", n_reads, 0);

    // Single flit to E with ack two cycles after req.
    r0 = n_reads;
    reset = 1'b1;
    drain();
    check("t2_reads", n_reads - r0, 1);

    // Unroutable flit dropped, following flit still delivered.
    check("t3_drops_before", drop_count, exp_drops);
    push(8'h11);
    push(8'h33);
    drain();
    check("t3_drops_after", drop_count, exp_drops);

    // Spurious ack on N while sending to L.
    ack_dly = 4;
    spur = 5'b00001;
    push(8'h4C);
    drain();
    spur = '0;

    // Back-to-back flits with the longest table latency.
    ack_dly = 1;
    r0 = n_reads;
    push(8'h05);
    push(8'h06);
    push(8'h07);
    drain();
    check("t5_reads", n_reads - r0, 3);

    // Reset in the middle of a handshake loses the held flit only.
    ack_dly = 30;
    push(8'h08);
    push(8'h09);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (fifo_pop_req != '0) break;
    end
    check("t6_send_lane", fifo_pop_req, 5'b01000);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    exp_drops = 0;
    #1;
    check("t6_req_async", fifo_pop_req, 0);
    check("t6_data_async", fifo_pop_data, 0);
    check("t6_busy_async", busy, 0);
    check("t6_fifo_kept", fifo_q.size(), 1);
    @(posedge clk);
    #2;
    ack_dly = 1;
    r0 = n_reads;
    reset = 1'b1;
    drain();
    check("t6_repop", n_reads - r0, 1);
    check("t6_drops", drop_count, exp_drops);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
